// File: rtl/phase_pkg.sv
`default_nettype none
// phase_pkg: opcode/function constants, instruction classes and sequencer
// state encoding shared by the phase sequencer and its decoder. Rev 1.0
package phase_pkg;

   localparam logic [5:0] OP_RTYPE  = 6'b000000;
   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_J      = 6'b000010;
   localparam logic [5:0] OP_JAL    = 6'b000011;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;
   localparam logic [5:0] OP_ADDIU  = 6'b001001;
   localparam logic [5:0] OP_ANDI   = 6'b001100;
   localparam logic [5:0] OP_ORI    = 6'b001101;
   localparam logic [5:0] OP_XORI   = 6'b001110;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_SW     = 6'b101011;

   localparam logic [5:0] FN_JR     = 6'b001000;
   localparam logic [5:0] FN_JALR   = 6'b001001;
   localparam logic [5:0] FN_ADD    = 6'b100000;
   localparam logic [5:0] FN_AND    = 6'b100100;
   localparam logic [5:0] FN_OR     = 6'b100101;
   localparam logic [5:0] FN_XOR    = 6'b100110;
   localparam logic [5:0] FN_NOR    = 6'b100111;
   localparam logic [5:0] FN_SLT    = 6'b101010;

   localparam logic [4:0] RI_BLTZ   = 5'b00000;
   localparam logic [4:0] RI_BGEZ   = 5'b00001;

   localparam int P0 = 0;
   localparam int P1 = 1;
   localparam int P2 = 2;
   localparam int P3 = 3;
   localparam int P4 = 4;

   typedef enum logic [2:0] {
      CL_RCALC = 3'd0,
      CL_ICALC = 3'd1,
      CL_LW    = 3'd2,
      CL_SW    = 3'd3,
      CL_BR    = 3'd4,
      CL_JMP   = 3'd5,
      CL_ILL   = 3'd6
   } instr_class_t;

   // Codes 6 and 7 are unused; the sequencer treats them as HALT.
   typedef enum logic [2:0] {
      ST_P0   = 3'd0,
      ST_P1   = 3'd1,
      ST_P2   = 3'd2,
      ST_P3   = 3'd3,
      ST_P4   = 3'd4,
      ST_HALT = 3'd5
   } phase_state_t;

   function automatic logic [4:0] phase_onehot(input int idx);
      logic [4:0] v;
      v = 5'b00001;
      return v << idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/phase_seq_if.sv
`default_nettype none
// phase_seq_if: IR/memory inputs and phase outputs of the phase sequencer.
// The step input exists only when SINGLE_STEP_EN is defined. Rev 1.0
interface phase_seq_if #(
   parameter int CNT_W = 32
);
   logic [5:0]       op;
   logic [5:0]       irfunc;
   logic [4:0]       regimm;
   logic             mem_ready;
`ifdef SINGLE_STEP_EN
   logic             step;
`endif
   logic [4:0]       p;
   logic             ir_load;
   logic             instr_done;
   logic             illegal;
   logic [CNT_W-1:0] retired;

`ifdef SINGLE_STEP_EN
   modport master (
      output op, irfunc, regimm, mem_ready, step,
      input  p, ir_load, instr_done, illegal, retired
   );
   modport slave (
      input  op, irfunc, regimm, mem_ready, step,
      output p, ir_load, instr_done, illegal, retired
   );
`else
   modport master (
      output op, irfunc, regimm, mem_ready,
      input  p, ir_load, instr_done, illegal, retired
   );
   modport slave (
      input  op, irfunc, regimm, mem_ready,
      output p, ir_load, instr_done, illegal, retired
   );
`endif
endinterface
`default_nettype wire

// File: rtl/instr_class_dec.sv
`default_nettype none
// instr_class_dec: combinational op/funct/rt -> instruction class decode.
// Anything not explicitly recognised decodes as CL_ILL. Rev 1.0
module instr_class_dec
   import phase_pkg::*;
(
   input  logic [5:0]   i_op,
   input  logic [5:0]   i_func,
   input  logic [4:0]   i_rt,
   output instr_class_t o_class
);

   always_comb begin
      o_class = CL_ILL;
      case (i_op)
         OP_RTYPE: begin
            case (i_func)
               FN_ADD, FN_SLT, FN_AND,
               FN_OR, FN_XOR, FN_NOR:  o_class = CL_RCALC;
               FN_JR, FN_JALR:         o_class = CL_JMP;
               default:                o_class = CL_ILL;
            endcase
         end
         OP_REGIMM: begin
            if ((i_rt == RI_BLTZ) || (i_rt == RI_BGEZ)) begin
               o_class = CL_BR;
            end
         end
         OP_LW:                                o_class = CL_LW;
         OP_SW:                                o_class = CL_SW;
         OP_J, OP_JAL:                         o_class = CL_JMP;
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:     o_class = CL_BR;
         OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI:   o_class = CL_ICALC;
         default:                              o_class = CL_ILL;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/phase_seq.sv
`default_nettype none
// phase_seq: one-hot p0..p4 phase sequencer with class-dependent paths,
// memory-wait stretching, illegal-op HALT and retire counter. Optional SINGLE_STEP_EN. Rev 1.0
module phase_seq
   import phase_pkg::*;
#(
   parameter int CNT_W = 32
)
(
   input  logic          clk,
   input  logic          reset,
   phase_seq_if.slave    bus
);

   phase_state_t     r_state;
   logic [4:0]       r_p;
   instr_class_t     r_class;
   logic             r_illegal;
   logic [CNT_W-1:0] r_retired;

   instr_class_t     w_class;
   logic             w_step_ok;
   logic             w_fetch;
   logic             w_done;

   instr_class_dec u_dec (
      .i_op    (bus.op),
      .i_func  (bus.irfunc),
      .i_rt    (bus.regimm),
      .o_class (w_class)
   );

`ifdef SINGLE_STEP_EN
   // Armed by a step pulse while waiting in p0; disarmed by each retirement.
   logic r_armed;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_armed <= 1'b0;
      end else if (w_done) begin
         r_armed <= 1'b0;
      end else if ((r_state == ST_P0) && bus.step) begin
         r_armed <= 1'b1;
      end
   end

   assign w_step_ok = r_armed | bus.step;
`else
   assign w_step_ok = 1'b1;
`endif

   assign w_fetch = (r_state == ST_P0) && bus.mem_ready && w_step_ok;

   assign w_done  = (r_state == ST_P4)
                 || ((r_state == ST_P3) && (r_class == CL_SW) && bus.mem_ready)
                 || ((r_state == ST_P2) && (r_class == CL_BR));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_P0;
         r_p       <= phase_onehot(P0);
         r_class   <= CL_ILL;
         r_illegal <= 1'b0;
         r_retired <= '0;
      end else begin
         if (w_done) begin
            r_retired <= r_retired + 1'b1;
         end
         case (r_state)
            ST_P0: begin
               if (w_fetch) begin
                  r_state <= ST_P1;
                  r_p     <= phase_onehot(P1);
               end
            end
            ST_P1: begin
               r_class <= w_class;
               if (w_class == CL_ILL) begin
                  r_state   <= ST_HALT;
                  r_p       <= '0;
                  r_illegal <= 1'b1;
               end else begin
                  r_state <= ST_P2;
                  r_p     <= phase_onehot(P2);
               end
            end
            ST_P2: begin
               case (r_class)
                  CL_BR: begin
                     r_state <= ST_P0;
                     r_p     <= phase_onehot(P0);
                  end
                  CL_LW, CL_SW: begin
                     r_state <= ST_P3;
                     r_p     <= phase_onehot(P3);
                  end
                  CL_RCALC, CL_ICALC, CL_JMP: begin
                     r_state <= ST_P4;
                     r_p     <= phase_onehot(P4);
                  end
                  default: begin
                     r_state   <= ST_HALT;
                     r_p       <= '0;
                     r_illegal <= 1'b1;
                  end
               endcase
            end
            ST_P3: begin
               if (bus.mem_ready) begin
                  if (r_class == CL_LW) begin
                     r_state <= ST_P4;
                     r_p     <= phase_onehot(P4);
                  end else begin
                     r_state <= ST_P0;
                     r_p     <= phase_onehot(P0);
                  end
               end
            end
            ST_P4: begin
               r_state <= ST_P0;
               r_p     <= phase_onehot(P0);
            end
            ST_HALT: begin
               r_p       <= '0;
               r_illegal <= 1'b1;
            end
            // Corrupted state encoding parks the sequencer like an illegal op.
            default: begin
               r_state   <= ST_HALT;
               r_p       <= '0;
               r_illegal <= 1'b1;
            end
         endcase
      end
   end

   assign bus.p          = r_p;
   assign bus.ir_load    = w_fetch;
   assign bus.instr_done = w_done;
   assign bus.illegal    = r_illegal;
   assign bus.retired    = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_phase_seq.sv
`default_nettype none
// tb_phase_seq: directed scoreboard bench for phase_seq; expected outputs are
// queued as each cycle is driven and popped when that cycle is sampled.
module tb_phase_seq;
   import phase_pkg::*;

   localparam int CNT_W  = 32;
   localparam int K_CALC = 0;
   localparam int K_LW   = 1;
   localparam int K_SW   = 2;
   localparam int K_BR   = 3;

   typedef struct packed {
      logic [4:0]       p;
      logic             irl;
      logic             done;
      logic             ill;
      logic [CNT_W-1:0] ret;
   } obs_t;

   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      logic [4:0] rt;
      int         kind;
      string      name;
   } instr_t;

   logic clk = 1'b0;
   logic reset;

   phase_seq_if #(.CNT_W(CNT_W)) bus ();

   phase_seq #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   obs_t             exp_q[$];
   int               n_vec   = 0;
   int               n_err   = 0;
   logic [CNT_W-1:0] exp_ret = '0;

   function automatic obs_t observe();
      return {bus.p, bus.ir_load, bus.instr_done, bus.illegal, bus.retired};
   endfunction

   task automatic push_exp(input logic [4:0] ep, input logic eirl, input logic edone,
                           input logic eill);
      exp_q.push_back({ep, eirl, edone, eill, exp_ret});
   endtask

   task automatic check(input string tag);
      obs_t e;
      obs_t o;
      n_vec++;
      if (exp_q.size() == 0) begin
         n_err++;
         $error("FAIL %s: scoreboard empty, observed p=%b", tag, bus.p);
      end else begin
         e = exp_q.pop_front();
         o = observe();
         assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed p=%b irl=%b done=%b ill=%b ret=%0d, expected p=%b irl=%b done=%b ill=%b ret=%0d",
                   tag, o.p, o.irl, o.done, o.ill, o.ret, e.p, e.irl, e.done, e.ill, e.ret);
         end
      end
   endtask

   // Drive one cycle's inputs, queue its expectation, sample mid-cycle.
   task automatic cyc(input string tag, input logic [5:0] o, input logic [5:0] f,
                      input logic [4:0] r, input logic mr, input logic [4:0] ep,
                      input logic eirl, input logic edone, input logic eill);
      bus.op        = o;
      bus.irfunc    = f;
      bus.regimm    = r;
      bus.mem_ready = mr;
      push_exp(ep, eirl, edone, eill);
      @(negedge clk);
      check(tag);
      @(posedge clk);
      #1;
   endtask

   // After p1 the IR fields are driven with garbage to confirm the class latch.
   task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                            input logic [4:0] r, input int kind, input int waits);
      cyc({tag, "_p0"}, o, f, r, 1'b1, 5'b00001, 1'b1, 1'b0, 1'b0);
      cyc({tag, "_p1"}, o, f, r, 1'b1, 5'b00010, 1'b0, 1'b0, 1'b0);
      cyc({tag, "_p2"}, 6'h3f, 6'h3f, 5'h1f, 1'b0, 5'b00100, 1'b0, (kind == K_BR), 1'b0);
      if (kind == K_BR) begin
         exp_ret++;
         return;
      end
      if ((kind == K_LW) || (kind == K_SW)) begin
         for (int w = 0; w < waits; w++) begin
            cyc({tag, "_p3w"}, 6'h3f, 6'h3f, 5'h1f, 1'b0, 5'b01000, 1'b0, 1'b0, 1'b0);
         end
         cyc({tag, "_p3"}, 6'h3f, 6'h3f, 5'h1f, 1'b1, 5'b01000, 1'b0, (kind == K_SW), 1'b0);
         if (kind == K_SW) begin
            exp_ret++;
            return;
         end
      end
      cyc({tag, "_p4"}, 6'h3f, 6'h3f, 5'h1f, 1'b0, 5'b10000, 1'b0, 1'b1, 1'b0);
      exp_ret++;
   endtask

   task automatic async_reset(input string tag);
      bus.mem_ready = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      exp_ret = '0;
      push_exp(5'b00001, 1'b0, 1'b0, 1'b0);
      check(tag);
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   instr_t tbl[$];

   initial begin
      reset         = 1'b0;
      bus.op        = '0;
      bus.irfunc    = '0;
      bus.regimm    = '0;
      bus.mem_ready = 1'b0;
`ifdef SINGLE_STEP_EN
      bus.step      = 1'b1;
`endif
      #1;
      cyc("reset", 6'h00, 6'h00, 5'h00, 1'b0, 5'b00001, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;

      run_instr("lw", OP_LW, 6'h00, 5'h00, K_LW, 2);
      run_instr("add", OP_RTYPE, FN_ADD, 5'h00, K_CALC, 0);
      run_instr("beq", OP_BEQ, 6'h00, 5'h00, K_BR, 0);

      tbl.push_back('{OP_SW,     6'h00,   5'h00,   K_SW,   "sw"});
      tbl.push_back('{OP_RTYPE,  FN_SLT,  5'h00,   K_CALC, "slt"});
      tbl.push_back('{OP_RTYPE,  FN_AND,  5'h00,   K_CALC, "and"});
      tbl.push_back('{OP_RTYPE,  FN_OR,   5'h00,   K_CALC, "or"});
      tbl.push_back('{OP_RTYPE,  FN_XOR,  5'h00,   K_CALC, "xor"});
      tbl.push_back('{OP_RTYPE,  FN_NOR,  5'h00,   K_CALC, "nor"});
      tbl.push_back('{OP_RTYPE,  FN_JR,   5'h00,   K_CALC, "jr"});
      tbl.push_back('{OP_RTYPE,  FN_JALR, 5'h00,   K_CALC, "jalr"});
      tbl.push_back('{OP_J,      6'h00,   5'h00,   K_CALC, "j"});
      tbl.push_back('{OP_JAL,    6'h00,   5'h00,   K_CALC, "jal"});
      tbl.push_back('{OP_ADDIU,  6'h00,   5'h00,   K_CALC, "addiu"});
      tbl.push_back('{OP_ANDI,   6'h00,   5'h00,   K_CALC, "andi"});
      tbl.push_back('{OP_XORI,   6'h00,   5'h00,   K_CALC, "xori"});
      tbl.push_back('{OP_BNE,    6'h00,   5'h00,   K_BR,   "bne"});
      tbl.push_back('{OP_BLEZ,   6'h00,   5'h00,   K_BR,   "blez"});
      tbl.push_back('{OP_BGTZ,   6'h00,   5'h00,   K_BR,   "bgtz"});
      tbl.push_back('{OP_REGIMM, 6'h00,   RI_BGEZ, K_BR,   "bgez"});
      tbl.push_back('{OP_REGIMM, 6'h00,   RI_BLTZ, K_BR,   "bltz"});
      tbl.push_back('{OP_SW,     6'h00,   5'h00,   K_SW,   "sw_wait"});
      for (int i = 0; i < tbl.size(); i++) begin
         run_instr(tbl[i].name, tbl[i].op, tbl[i].fn, tbl[i].rt, tbl[i].kind,
                   (tbl[i].name == "sw_wait") ? 1 : 0);
      end

      // Fetch wait, then reset asynchronously inside a stalled SW p3.
      for (int i = 0; i < 3; i++) begin
         cyc("fwait", OP_SW, 6'h00, 5'h00, 1'b0, 5'b00001, 1'b0, 1'b0, 1'b0);
      end
      cyc("fgo", OP_SW, 6'h00, 5'h00, 1'b1, 5'b00001, 1'b1, 1'b0, 1'b0);
      cyc("sw_p1", OP_SW, 6'h00, 5'h00, 1'b1, 5'b00010, 1'b0, 1'b0, 1'b0);
      cyc("sw_p2", OP_SW, 6'h00, 5'h00, 1'b1, 5'b00100, 1'b0, 1'b0, 1'b0);
      cyc("sw_p3", OP_SW, 6'h00, 5'h00, 1'b0, 5'b01000, 1'b0, 1'b0, 1'b0);
      async_reset("rst_mid_sw");
      run_instr("ori_after_rst", OP_ORI, 6'h00, 5'h00, K_CALC, 0);

      // Illegal opcode: HALT for 20 cycles, cleared only by reset.
      cyc("ill_p0", 6'h3f, 6'h00, 5'h00, 1'b1, 5'b00001, 1'b1, 1'b0, 1'b0);
      cyc("ill_p1", 6'h3f, 6'h00, 5'h00, 1'b1, 5'b00010, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         cyc("halt", OP_ADDIU, 6'h00, 5'h00, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b1);
      end
      async_reset("rst_halt");

      // Unrecognised R-type function also halts.
      cyc("illfn_p0", OP_RTYPE, 6'h3f, 5'h00, 1'b1, 5'b00001, 1'b1, 1'b0, 1'b0);
      cyc("illfn_p1", OP_RTYPE, 6'h3f, 5'h00, 1'b1, 5'b00010, 1'b0, 1'b0, 1'b0);
      cyc("illfn_halt", OP_RTYPE, FN_ADD, 5'h00, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b1);
      async_reset("rst_illfn");
      run_instr("add_after_halt", OP_RTYPE, FN_ADD, 5'h00, K_CALC, 0);

`ifdef SINGLE_STEP_EN
      bus.step = 1'b0;
      async_reset("rst_step");
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 3; i++) begin
            cyc("step_wait", OP_ORI, 6'h00, 5'h00, 1'b1, 5'b00001, 1'b0, 1'b0, 1'b0);
         end
         bus.step = 1'b1;
         cyc("step_p0", OP_ORI, 6'h00, 5'h00, 1'b1, 5'b00001, 1'b1, 1'b0, 1'b0);
         bus.step = 1'b0;
         cyc("step_p1", OP_ORI, 6'h00, 5'h00, 1'b1, 5'b00010, 1'b0, 1'b0, 1'b0);
         cyc("step_p2", OP_ORI, 6'h00, 5'h00, 1'b1, 5'b00100, 1'b0, 1'b0, 1'b0);
         cyc("step_p4", OP_ORI, 6'h00, 5'h00, 1'b1, 5'b10000, 1'b0, 1'b1, 1'b0);
         exp_ret++;
      end
      cyc("step_end", OP_ORI, 6'h00, 5'h00, 1'b1, 5'b00001, 1'b0, 1'b0, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/phase_seq.md
Name: phase_seq

Overview:
- Multi-cycle phase sequencer directly upstream of the control unit.
- Generates the one-hot phase vector p[4:0] (p0 fetch, p1 decode, p2 execute, p3 memory, p4 writeback) consumed by the CU.
- Decodes the instruction class from op/irfunc/regimm to pick each instruction's phase path.
- Stretches p0/p3 on memory wait, flags illegal opcodes and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  6  IR opcode field; valid from the first p1 cycle onward.
- irfunc  in  6  IR function field (R-type).
- regimm  in  5  IR rt field (REGIMM branches).
- mem_ready  in  1  memory completion for fetch (p0) and lw/sw access (p3).
- p  out  5  one-hot phase vector, p[k]=1 in phase k; all-zero only when halted.
- ir_load  out  1  high in the p0 cycle where mem_ready=1 (IR captures that edge).
- instr_done  out  1  one-cycle pulse in the final phase cycle of each instruction.
- illegal  out  1  sticky; set on unrecognised instruction.
- retired  out  CNT_W  count of completed instructions; wraps modulo 2^CNT_W.

Behaviour:
- Reset asserted (any time, including mid-instruction):
  - p=5'b00001, illegal=0, retired=0, instr_done=0.
  - First fetch begins on the first edge after deassertion.
- Classes decoded in p1 from op/irfunc/regimm:
  - R-calc: add, slt, and, or, xor, nor.
  - I-calc: addiu, andi, ori, xori.
  - LW, SW.
  - BR: beq, bne, bgez, bgtz, blez, bltz.
  - JMP: j, jal, jr, jalr.
- Phase paths:
  - LW: p0-p1-p2-p3-p4.
  - SW: p0-p1-p2-p3.
  - R-calc, I-calc, JMP: p0-p1-p2-p4 (p3 skipped).
  - BR: p0-p1-p2.
- Illegal instruction:
  - Class recorded at p1 exit; transition to HALT.
  - In HALT: p=0, illegal=1, no further retirement.
  - HALT is left only by reset.
- Handshake:
  - p0 holds while mem_ready=0 and advances to p1 on the edge where mem_ready=1.
  - p3 holds likewise.
  - p1, p2 and p4 last exactly one cycle; mem_ready is ignored there.
- Class latch:
  - Class is registered at p1 exit and used for all later transitions.
  - op changes after p1 do not alter the path.
- Retirement:
  - instr_done=1 and retired increments by 1 on the final-phase edge.
  - A stalled p3 retires only on its completing cycle.
- Back-to-back instructions: the final phase is followed directly by p0; there are no idle cycles.
- Minimum cycles per class: LW 5, SW 4, calc/JMP 4, BR 3 (plus memory wait cycles).
- One-hot invariant: exactly one p bit is set outside HALT. An illegal encoding of the state register forces HALT.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- With the macro defined:
  - Adds input step (1 bit).
  - After every retirement the sequencer waits in p0 with ir_load suppressed until a cycle with step=1.
  - From that point mem_ready handling is normal.
  - The first instruction after reset also waits for step.
- Without the macro: no step port; fetch is continuous.

Decomposition:
- Package phase_pkg:
  - Opcode constants: OP_RTYPE, OP_REGIMM, OP_LW, OP_SW, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI.
  - Function constants: FN_ADD, FN_SLT, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_JR, FN_JALR.
  - REGIMM constants: RI_BLTZ, RI_BGEZ.
  - Phase index constants P0..P4.
  - Class enum: CL_RCALC, CL_ICALC, CL_LW, CL_SW, CL_BR, CL_JMP, CL_ILL.
- One combinational sub-module, instr_class_dec: op/irfunc/regimm -> class.
- The sequencer FSM and counter stay in phase_seq.

Test Plan:
- LW (op=6'b100011):
  - Stimulus: mem_ready=1 except 2 wait cycles in p3.
  - Required p sequence: 00001, 00010, 00100, 01000 ×3, 10000, then 00001.
  - instr_done in the 10000 cycle; retired 0→1.
- add (op=0, irfunc=6'b100000) then beq (op=6'b000100), with mem_ready=1:
  - add: p0, p1, p2, p4.
  - beq: p0, p1, p2.
  - 7 cycles total; retired=2.
- op=6'b111111 at p1:
  - Next cycle p=0, illegal=1.
  - Holds 20 cycles with no retire.
  - Reset low then high -> p=00001, illegal=0.
- Reset:
  - Assert reset in p3 of SW with mem_ready=0.
  - p=00001 immediately (asynchronous), retired=0.
  - Fetch resumes after release.
- Fetch wait: mem_ready=0 for 3 cycles in p0 -> p stays 00001 with ir_load=0, then ir_load=1 for one cycle and advance to p1.
- With SINGLE_STEP_EN, run two ori instructions:
  - p0 stays stalled until step=1.
  - Each ori retires in 4 cycles after its step pulse; retired=2.
